// File: rtl/reg_writeback_ctrl.sv
// Register file write-port sequencer: merges ALU results, reg-to-reg moves and
// variable-latency load returns into one registered write per cycle.
module reg_writeback_ctrl #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         alu_valid,
    input  logic [D-1:0] alu_dest,
    input  logic [W-1:0] alu_data,
    input  logic         mov_valid,
    input  logic [D-1:0] mov_dest,
    input  logic [D-1:0] mov_src,
    input  logic         load_issue,
    input  logic [D-1:0] load_dest,
    input  logic         mem_valid,
    input  logic [W-1:0] mem_data,
    output logic         stall,
    input  logic [D-1:0] check_reg,
    output logic         check_busy,
    output logic         write_enabled,
    output logic         reg_to_reg,
    output logic [D-1:0] reg_write_number,
    output logic [D-1:0] reg_from_number,
    output logic [W-1:0] reg_write_data
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t         state_r;
    logic [D-1:0]   pend_dest_r;
    logic           skid_mov_r;
    logic [D-1:0]   skid_dest_r;
    logic [D-1:0]   skid_src_r;
    logic [W-1:0]   skid_data_r;

    logic           acc_load_s;
    logic           acc_mov_s;
    logic           acc_alu_s;

    // Request arbitration: pick the highest-priority request that has no hazard.
    always_comb begin
        acc_load_s = 1'b0;
        acc_mov_s  = 1'b0;
        acc_alu_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_issue) begin
                    acc_load_s = 1'b1;
                end else if (mov_valid) begin
                    acc_mov_s = 1'b1;
                end else if (alu_valid) begin
                    acc_alu_s = 1'b1;
                end else begin
                    acc_load_s = 1'b0;
                end
            end
            WAIT_MEM: begin
                // Only one load may be outstanding; ops touching its destination wait.
                if (mov_valid && (mov_dest != pend_dest_r) && (mov_src != pend_dest_r)) begin
                    acc_mov_s = 1'b1;
                end else if (alu_valid && (alu_dest != pend_dest_r)) begin
                    acc_alu_s = 1'b1;
                end else begin
                    acc_mov_s = 1'b0;
                end
            end
            default: begin
                acc_load_s = 1'b0;
            end
        endcase
    end

    // Any asserted request that was not accepted must be held upstream.
    always_comb begin
        stall      = (load_issue & ~acc_load_s) | (mov_valid & ~acc_mov_s) | (alu_valid & ~acc_alu_s);
        check_busy = (state_r == WAIT_MEM) && (check_reg == pend_dest_r);
    end

    // Sequencer state, load tracking, skid buffer and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= IDLE;
            pend_dest_r      <= {D{1'b0}};
            skid_mov_r       <= 1'b0;
            skid_dest_r      <= {D{1'b0}};
            skid_src_r       <= {D{1'b0}};
            skid_data_r      <= {W{1'b0}};
            write_enabled    <= 1'b0;
            reg_to_reg       <= 1'b0;
            reg_write_number <= {D{1'b0}};
            reg_from_number  <= {D{1'b0}};
            reg_write_data   <= {W{1'b0}};
        end else begin
            write_enabled <= 1'b0;
            reg_to_reg    <= 1'b0;
            case (state_r)
                IDLE, WAIT_MEM: begin
                    if ((state_r == WAIT_MEM) && mem_valid) begin
                        write_enabled    <= 1'b1;
                        reg_write_number <= pend_dest_r;
                        reg_write_data   <= mem_data;
                        // The load write owns the port; a same-cycle op is parked.
                        if (acc_mov_s || acc_alu_s) begin
                            skid_mov_r  <= acc_mov_s;
                            skid_dest_r <= acc_mov_s ? mov_dest : alu_dest;
                            skid_src_r  <= mov_src;
                            skid_data_r <= alu_data;
                            state_r     <= DRAIN;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (acc_load_s) begin
                        pend_dest_r <= load_dest;
                        state_r     <= WAIT_MEM;
                    end else if (acc_mov_s) begin
                        reg_to_reg       <= 1'b1;
                        reg_write_number <= mov_dest;
                        reg_from_number  <= mov_src;
                    end else if (acc_alu_s) begin
                        write_enabled    <= 1'b1;
                        reg_write_number <= alu_dest;
                        reg_write_data   <= alu_data;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DRAIN: begin
                    reg_write_number <= skid_dest_r;
                    if (skid_mov_r) begin
                        reg_to_reg      <= 1'b1;
                        reg_from_number <= skid_src_r;
                    end else begin
                        write_enabled  <= 1'b1;
                        reg_write_data <= skid_data_r;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed self-checking bench for reg_writeback_ctrl.
module tb_reg_writeback_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         alu_valid, mov_valid, load_issue, mem_valid;
    logic [D-1:0] alu_dest, mov_dest, mov_src, load_dest, check_reg;
    logic [W-1:0] alu_data, mem_data;
    logic         stall, check_busy, write_enabled, reg_to_reg;
    logic [D-1:0] reg_write_number, reg_from_number;
    logic [W-1:0] reg_write_data;

    int checks = 0;
    int passed = 0;

    reg_writeback_ctrl #(.W(W), .D(D)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .mov_valid(mov_valid), .mov_dest(mov_dest), .mov_src(mov_src),
        .load_issue(load_issue), .load_dest(load_dest),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .stall(stall), .check_reg(check_reg), .check_busy(check_busy),
        .write_enabled(write_enabled), .reg_to_reg(reg_to_reg),
        .reg_write_number(reg_write_number), .reg_from_number(reg_from_number),
        .reg_write_data(reg_write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port(input string tag, input logic we, input logic rr,
                        input logic [D-1:0] wn, input logic [D-1:0] fn, input logic [W-1:0] wd);
        chk({tag, ".we"}, {31'd0, write_enabled}, {31'd0, we});
        chk({tag, ".r2r"}, {31'd0, reg_to_reg}, {31'd0, rr});
        chk({tag, ".wnum"}, {28'd0, reg_write_number}, {28'd0, wn});
        chk({tag, ".fnum"}, {28'd0, reg_from_number}, {28'd0, fn});
        chk({tag, ".wdata"}, {24'd0, reg_write_data}, {24'd0, wd});
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; mov_valid = 1'b0; load_issue = 1'b0; mem_valid = 1'b0;
        alu_dest = 4'd0; mov_dest = 4'd0; mov_src = 4'd0; load_dest = 4'd0; check_reg = 4'd0;
        alu_data = 8'h00; mem_data = 8'h00;
        tick(); tick();
        port("reset", 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        chk("reset.stall", {31'd0, stall}, 32'd0);
        chk("reset.busy", {31'd0, check_busy}, 32'd0);
        reset = 1'b0;

        // ALU write
        alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 8'h5A;
        #1 chk("alu.stall", {31'd0, stall}, 32'd0);
        tick(); alu_valid = 1'b0;
        port("alu.w", 1'b1, 1'b0, 4'd3, 4'd0, 8'h5A);
        tick();
        port("alu.hold", 1'b0, 1'b0, 4'd3, 4'd0, 8'h5A);

        // Register-to-register move
        mov_valid = 1'b1; mov_dest = 4'd2; mov_src = 4'd7;
        #1 chk("mov.stall", {31'd0, stall}, 32'd0);
        tick(); mov_valid = 1'b0;
        port("mov.w", 1'b0, 1'b1, 4'd2, 4'd7, 8'h5A);
        tick();
        port("mov.hold", 1'b0, 1'b0, 4'd2, 4'd7, 8'h5A);

        // Load with hazards
        load_issue = 1'b1; load_dest = 4'd4;
        #1 chk("ld.stall", {31'd0, stall}, 32'd0);
        tick(); load_issue = 1'b0;
        chk("ld.nowrite", {31'd0, write_enabled}, 32'd0);
        check_reg = 4'd4;
        #1 chk("ld.busy4", {31'd0, check_busy}, 32'd1);
        check_reg = 4'd5;
        #1 chk("ld.busy5", {31'd0, check_busy}, 32'd0);
        alu_valid = 1'b1; alu_dest = 4'd4; alu_data = 8'h66;
        #1 chk("ld.waw_alu", {31'd0, stall}, 32'd1);
        alu_valid = 1'b0; mov_valid = 1'b1; mov_dest = 4'd9; mov_src = 4'd4;
        #1 chk("ld.raw_mov", {31'd0, stall}, 32'd1);
        mov_valid = 1'b0;
        tick();
        chk("ld.stalled_nowrite", {31'd0, write_enabled}, 32'd0);
        alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 8'h77;
        #1 chk("ld.alu5_stall", {31'd0, stall}, 32'd0);
        tick(); alu_valid = 1'b0;
        port("ld.alu5", 1'b1, 1'b0, 4'd5, 4'd7, 8'h77);
        mem_valid = 1'b1; mem_data = 8'hC3;
        tick(); mem_valid = 1'b0;
        port("ld.ret", 1'b1, 1'b0, 4'd4, 4'd7, 8'hC3);
        check_reg = 4'd4;
        #1 chk("ld.busy_drop", {31'd0, check_busy}, 32'd0);
        tick();
        chk("ld.after", {31'd0, write_enabled}, 32'd0);

        // Collision: load return with same-cycle ALU accept
        load_issue = 1'b1; load_dest = 4'd1;
        tick(); load_issue = 1'b0;
        mem_valid = 1'b1; mem_data = 8'h11; alu_valid = 1'b1; alu_dest = 4'd6; alu_data = 8'h22;
        #1 chk("col.stall", {31'd0, stall}, 32'd0);
        tick(); mem_valid = 1'b0; alu_valid = 1'b0;
        port("col.N1", 1'b1, 1'b0, 4'd1, 4'd7, 8'h11);
        alu_valid = 1'b1; alu_dest = 4'd8; alu_data = 8'h33;
        #1 chk("col.drain_stall", {31'd0, stall}, 32'd1);
        alu_valid = 1'b0;
        tick();
        port("col.N2", 1'b1, 1'b0, 4'd6, 4'd7, 8'h22);
        tick();
        chk("col.idle", {31'd0, write_enabled}, 32'd0);

        // Priority: load > move > ALU
        load_issue = 1'b1; load_dest = 4'd10;
        mov_valid = 1'b1; mov_dest = 4'd3; mov_src = 4'd2;
        alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 8'h99;
        #1 chk("pri.stall0", {31'd0, stall}, 32'd1);
        tick(); load_issue = 1'b0;
        chk("pri.noload_write", {31'd0, write_enabled | reg_to_reg}, 32'd0);
        #1 chk("pri.stall1", {31'd0, stall}, 32'd1);
        tick(); mov_valid = 1'b0;
        port("pri.mov", 1'b0, 1'b1, 4'd3, 4'd2, 8'h22);
        #1 chk("pri.stall2", {31'd0, stall}, 32'd0);
        tick(); alu_valid = 1'b0;
        port("pri.alu", 1'b1, 1'b0, 4'd5, 4'd2, 8'h99);
        mem_valid = 1'b1; mem_data = 8'hAB;
        tick(); mem_valid = 1'b0;
        port("pri.ld", 1'b1, 1'b0, 4'd10, 4'd2, 8'hAB);

        // Load issue colliding with load return
        load_issue = 1'b1; load_dest = 4'd3;
        tick();
        load_dest = 4'd12; mem_valid = 1'b1; mem_data = 8'h42;
        #1 chk("ll.stall", {31'd0, stall}, 32'd1);
        tick(); mem_valid = 1'b0;
        port("ll.ret", 1'b1, 1'b0, 4'd3, 4'd2, 8'h42);
        #1 chk("ll.idle_accept", {31'd0, stall}, 32'd0);
        tick(); load_issue = 1'b0;
        check_reg = 4'd12;
        #1 chk("ll.busy12", {31'd0, check_busy}, 32'd1);
        mem_valid = 1'b1; mem_data = 8'h13;
        tick(); mem_valid = 1'b0;
        port("ll.ret2", 1'b1, 1'b0, 4'd12, 4'd2, 8'h13);

        // Reset mid-load with a write in flight
        tick();
        load_issue = 1'b1; load_dest = 4'd7;
        tick(); load_issue = 1'b0;
        alu_valid = 1'b1; alu_dest = 4'd2; alu_data = 8'h55;
        tick(); alu_valid = 1'b0;
        chk("rst.inflight", {31'd0, write_enabled}, 32'd1);
        reset = 1'b1; check_reg = 4'd7;
        #1 port("rst.during", 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        chk("rst.busy", {31'd0, check_busy}, 32'd0);
        tick(); reset = 1'b0;
        mem_valid = 1'b1; mem_data = 8'hEE;
        tick(); mem_valid = 1'b0;
        port("rst.after", 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        chk("rst.busy_after", {31'd0, check_busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Sole driver of the register file write port (write_enabled, reg_to_reg, reg_write_number, reg_from_number, reg_write_data).
- Sequences ALU results, register-to-register moves and variable-latency data-memory load returns into one registered write per cycle.
- Tracks the single outstanding load and stalls decode on hazards against its destination; a one-entry skid buffer absorbs ALU/load collisions.

Parameters:
W, 8, data width; matches register file W
D, 4, register index width; 2**D registers, register 0 is the accumulator

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
alu_valid  input  1  ALU result request
alu_dest  input  D  ALU destination register
alu_data  input  W  ALU result
mov_valid  input  1  register-to-register move request
mov_dest  input  D  move destination
mov_src  input  D  move source
load_issue  input  1  load issued to data memory; reserves load_dest
load_dest  input  D  load destination register
mem_valid  input  1  load data returned (one-cycle pulse)
mem_data  input  W  returned load data
stall  output  1  combinational; asserted request is not accepted this cycle, upstream must hold it
check_reg  input  D  register index queried by decode
check_busy  output  1  combinational; check_reg has a pending load write
write_enabled  output  1  registered; write reg_write_data to reg_write_number
reg_to_reg  output  1  registered; copy reg_from_number into reg_write_number
reg_write_number  output  D  registered write index
reg_from_number  output  D  registered move source index
reg_write_data  output  W  registered write data

Behaviour:
- States: IDLE, WAIT_MEM, DRAIN. Reset -> IDLE; all outputs 0, pend_dest = 0, skid buffer empty.
- At most one request is accepted per cycle. Priority is load_issue > mov_valid > alu_valid. Stall = 1 whenever any asserted request is not accepted.
- ALU accept: next cycle write_enabled = 1, reg_to_reg = 0, reg_write_number = alu_dest, reg_write_data = alu_data. Latency is 1 cycle, pulse is 1 cycle.
- Move accept: next cycle reg_to_reg = 1, write_enabled = 0, reg_write_number = mov_dest, reg_from_number = mov_src.
- write_enabled and reg_to_reg are never both 1. When neither is asserted, the index and data outputs hold their last values.
- IDLE:
  - load_issue is accepted. Latch pend_dest = load_dest and go to WAIT_MEM. No write is produced.
  - mem_valid is ignored.
- WAIT_MEM:
  - Stall a new load_issue.
  - Stall an ALU request if alu_dest == pend_dest (WAW).
  - Stall a move if mov_dest == pend_dest or mov_src == pend_dest (WAW/RAW).
  - Otherwise accept as in IDLE.
- mem_valid in WAIT_MEM:
  - Next cycle: write_enabled = 1, reg_write_number = pend_dest, reg_write_data = mem_data.
  - If no ALU/move was accepted the same cycle, return to IDLE.
  - If an ALU/move was accepted the same cycle, the load write wins. The accepted op goes into the skid buffer; go to DRAIN.
- DRAIN: stall = 1 for all requests. Next cycle the skid op drives the port, then return to IDLE. A load write is therefore always followed by the skid write, with no gap.
- check_busy = (state == WAIT_MEM) && (check_reg == pend_dest). It drops in the cycle the load write is presented on the port.
- A load_issue and mem_valid in the same cycle in WAIT_MEM: load_issue stalls. It is accepted in the following IDLE cycle.
- Reset mid-operation:
  - Pending load is abandoned; pend_dest and skid are cleared.
  - A later mem_valid is ignored, since the block is in IDLE.
  - A write in flight on the port is dropped; outputs are 0 during and after reset.
- Destination register 0 (accumulator) gets no special treatment.

Test Plan:
- ALU write: alu_valid, alu_dest = 3, alu_data = 8'h5A -> next cycle write_enabled = 1, reg_write_number = 3, reg_write_data = 8'h5A for exactly one cycle; stall = 0.
- Move: mov_valid, mov_dest = 2, mov_src = 7 -> next cycle reg_to_reg = 1, write_enabled = 0, reg_write_number = 2, reg_from_number = 7.
- Load with hazards:
  - load_issue, load_dest = 4; check_reg = 4 -> check_busy = 1.
  - alu_dest = 4 -> stall = 1; alu_dest = 5 -> accepted.
  - mem_valid, mem_data = 8'hC3 three cycles later -> next cycle write to reg 4 = 8'hC3; check_busy = 0 thereafter.
- Collision: in WAIT_MEM (dest 1), mem_valid = 8'h11 together with alu_valid dest 6 = 8'h22 -> cycle N+1 writes reg 1 = 8'h11, cycle N+2 writes reg 6 = 8'h22; stall = 1 during DRAIN.
- Priority: load_issue, mov_valid and alu_valid together in IDLE -> load accepted, stall = 1. Next cycle (WAIT_MEM) the move is accepted if there is no hazard, then the ALU op.
- Reset mid-load: reset asserted in WAIT_MEM, then mem_valid pulses -> no write is produced, check_busy = 0, all outputs stay 0.
